// File: rtl/ct_f_spsram_pkg.sv
// Shared definitions for the 256x54 single-port SRAM requester controller.
//   - default geometry of the wrapped SRAM (address, data, write-group width)
//   - number of independent write groups in one data word
//   - controller FSM state encoding
package ct_f_spsram_pkg;

    localparam int CT_ADDR_WIDTH = 8;
    localparam int CT_DATA_WIDTH = 54;
    localparam int CT_WRAP_SIZE  = 27;
    localparam int CT_GRP_NUM    = CT_DATA_WIDTH / CT_WRAP_SIZE;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_RMW_RD = 2'd2,
        ST_RMW_WR = 2'd3
    } ct_spsram_state_e;

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Read-response FIFO for the SRAM controller.
//   CLK        in   clock, posedge
//   cpurst_b   in   synchronous active-low reset (empties the FIFO)
//   push       in   write push_data into the tail
//   push_data  in   DATA_WIDTH entry to store
//   pop        in   drop the head entry (ignored when empty)
//   head_data  out  current head entry
//   empty      out  no entries stored
//   count      out  number of entries stored
// Push and pop may happen in the same cycle, including when full.
module ct_f_spsram_rsp_fifo #(
    parameter int DATA_WIDTH = 54,
    parameter int RSP_DEPTH  = 4,
    parameter int CNT_WIDTH  = $clog2(RSP_DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  full;
    logic                  push_ok;
    logic                  pop_ok;

    assign full      = (count_q == CNT_WIDTH'(RSP_DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ct_f_spsram_ctrl_256x54.sv
// Requester-side controller for one ct_f_spsram_256x54 wrapper.
// Converts a valid/ready read/write request stream into the wrapper's
// active-low CEN/GWEN/WEN protocol, returns read data in order through a
// credit-checked response FIFO, runs masks that split a write group as
// read-modify-write, and optionally zero-fills the array after reset.
//   CLK, cpurst_b                 clock / synchronous active-low reset
//   req_vld/req_rdy               request handshake
//   req_wr, req_addr              1 = write, word address
//   req_wdata, req_wmask          write data, active-high bit mask
//   rsp_vld/rsp_rdy, rsp_rdata    read response stream (request order)
//   A, CEN, GWEN, WEN, D          registered SRAM pins (active-low enables)
//   Q                             SRAM read data, valid the cycle after a read
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_INIT   | zero-fill sweep, one address per cycle, requests blocked
// ST_IDLE   | accept one read / aligned write per cycle
// ST_RMW_RD | SRAM read of an unaligned write's word is on the pins
// ST_RMW_WR | Q holds the old word; merge and write it back
module ct_f_spsram_ctrl_256x54
    import ct_f_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = CT_ADDR_WIDTH,
    parameter int DATA_WIDTH = CT_DATA_WIDTH,
    parameter int WRAP_SIZE  = CT_WRAP_SIZE,
    parameter int RSP_DEPTH  = 4,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    localparam int GRP_NUM = DATA_WIDTH / WRAP_SIZE;
    localparam int CW      = $clog2(RSP_DEPTH + 1);
    localparam ct_spsram_state_e RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_IDLE;

    ct_spsram_state_e      state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
    logic                  sram_cen_q, sram_cen_d;
    logic                  sram_gwen_q, sram_gwen_d;
    logic [DATA_WIDTH-1:0] sram_wen_q, sram_wen_d;
    logic [DATA_WIDTH-1:0] sram_d_q, sram_d_d;
    logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
    logic [DATA_WIDTH-1:0] rmw_wdata_q, rmw_wdata_d;
    logic [DATA_WIDTH-1:0] rmw_wmask_q, rmw_wmask_d;
    // Response-read pipeline: p1 = read on the pins, p2 = its Q is valid now.
    logic                  rd_p1_q, rd_p1_d;
    logic                  rd_p2_q, rd_p2_d;

    logic [GRP_NUM-1:0]    grp_full;
    logic [GRP_NUM-1:0]    grp_zero;
    logic [DATA_WIDTH-1:0] aligned_wen;
    logic                  wr_aligned;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [CW:0]           occupancy;
    logic                  credit_ok;
    logic                  req_fire;

    for (genvar g = 0; g < GRP_NUM; g++) begin : g_grp
        assign grp_full[g] = &req_wmask[g*WRAP_SIZE +: WRAP_SIZE];
        assign grp_zero[g] = ~|req_wmask[g*WRAP_SIZE +: WRAP_SIZE];
        assign aligned_wen[g*WRAP_SIZE +: WRAP_SIZE] = {WRAP_SIZE{~grp_full[g]}};
    end

    assign wr_aligned = &(grp_full | grp_zero);

    // Reads still in the pipe already own a FIFO slot, so they count
    // against the credit even though they have not been pushed yet.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(rd_p1_q) + (CW+1)'(rd_p2_q);
    assign credit_ok = (occupancy < (CW+1)'(RSP_DEPTH));
    assign req_rdy   = cpurst_b && (state_q == ST_IDLE) && (req_wr || credit_ok);
    assign req_fire  = req_vld && req_rdy;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        sram_a_d    = sram_a_q;
        sram_d_d    = sram_d_q;
        sram_cen_d  = 1'b1;
        sram_gwen_d = 1'b1;
        sram_wen_d  = '1;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_wmask_d = rmw_wmask_q;
        rd_p1_d     = 1'b0;
        rd_p2_d     = rd_p1_q;

        case (state_q)
            ST_INIT: begin
                sram_a_d    = init_cnt_q;
                sram_d_d    = '0;
                sram_cen_d  = 1'b0;
                sram_gwen_d = 1'b0;
                sram_wen_d  = '0;
                init_cnt_d  = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_fire) begin
                    sram_a_d   = req_addr;
                    sram_cen_d = 1'b0;
                    if (!req_wr) begin
                        rd_p1_d = 1'b1;
                    end else if (wr_aligned) begin
                        // An empty mask still takes the slot but writes nothing.
                        sram_gwen_d = ~|req_wmask;
                        sram_wen_d  = aligned_wen;
                        sram_d_d    = req_wdata;
                    end else begin
                        rmw_addr_d  = req_addr;
                        rmw_wdata_d = req_wdata;
                        rmw_wmask_d = req_wmask;
                        state_d     = ST_RMW_RD;
                    end
                end
            end
            ST_RMW_RD: begin
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                sram_a_d    = rmw_addr_q;
                sram_cen_d  = 1'b0;
                sram_gwen_d = 1'b0;
                sram_wen_d  = '0;
                sram_d_d    = (Q & ~rmw_wmask_q) | (rmw_wdata_q & rmw_wmask_q);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            state_q     <= RST_STATE;
            init_cnt_q  <= '0;
            sram_a_q    <= '0;
            sram_cen_q  <= 1'b1;
            sram_gwen_q <= 1'b1;
            sram_wen_q  <= '1;
            sram_d_q    <= '0;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_wmask_q <= '0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            sram_a_q    <= sram_a_d;
            sram_cen_q  <= sram_cen_d;
            sram_gwen_q <= sram_gwen_d;
            sram_wen_q  <= sram_wen_d;
            sram_d_q    <= sram_d_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_wdata_q <= rmw_wdata_d;
            rmw_wmask_q <= rmw_wmask_d;
            rd_p1_q     <= rd_p1_d;
            rd_p2_q     <= rd_p2_d;
        end
    end

    ct_f_spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH),
        .CNT_WIDTH  (CW)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .cpurst_b  (cpurst_b),
        .push      (rd_p2_q),
        .push_data (Q),
        .pop       (rsp_rdy),
        .head_data (rsp_rdata),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_vld = !fifo_empty;

    assign A    = sram_a_q;
    assign CEN  = sram_cen_q;
    assign GWEN = sram_gwen_q;
    assign WEN  = sram_wen_q;
    assign D    = sram_d_q;

endmodule

// File: tb/tb_ct_f_spsram_ctrl_256x54.sv
module tb_ct_f_spsram_ctrl_256x54;

    logic        CLK;
    logic        cpurst_b;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [53:0] req_wdata;
    logic [53:0] req_wmask;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [53:0] rsp_rdata;
    logic [7:0]  A;
    logic        CEN;
    logic        GWEN;
    logic [53:0] WEN;
    logic [53:0] D;
    logic [53:0] Q;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    ct_f_spsram_ctrl_256x54 dut (
        .CLK       (CLK),
        .cpurst_b  (cpurst_b),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .A         (A),
        .CEN       (CEN),
        .GWEN      (GWEN),
        .WEN       (WEN),
        .D         (D),
        .Q         (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural single-port SRAM; starts with garbage so the zero-fill is visible.
    logic [53:0] mem [256] = '{default: 54'h2D5A5AA5A53C3C};
    logic [53:0] q_r = '0;
    assign Q = q_r;
    always @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            else       q_r    <= mem[A];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [7:0] addr,
                        input logic [53:0] wdata, input logic [53:0] wmask);
        int n;
        req_vld = 1'b1; req_wr = wr; req_addr = addr;
        req_wdata = wdata; req_wmask = wmask;
        #1; n = 0;
        while (!req_rdy && n < 300) begin @(negedge CLK); #1; n++; end
        chk("send_rdy", req_rdy, 1);
        @(posedge CLK);
        @(negedge CLK);
        req_vld = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [53:0] exp, output int lat);
        lat = 1; #1;
        while (!rsp_vld && lat < 40) begin @(negedge CLK); #1; lat++; end
        chk({tag, "_vld"}, rsp_vld, 1);
        chk(tag, rsp_rdata, exp);
        @(negedge CLK);
    endtask

    task automatic wait_init(output int n);
        n = 0; #1;
        while (!req_rdy && n < 400) begin n++; @(negedge CLK); #1; end
    endtask

    logic [7:0]  bp_addr [8];
    logic [53:0] bp_exp  [8];
    int lat, n, idx, ridx;

    initial begin
        cpurst_b = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;

        // Reset values
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_cen",     CEN, 1);
        chk("rst_gwen",    GWEN, 1);
        chk("rst_wen",     WEN, 54'h3FFFFFFFFFFFFF);
        chk("rst_a",       A, 0);
        chk("rst_d",       D, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);

        // Zero-fill sweep keeps req_rdy low for 256 cycles
        @(negedge CLK);
        cpurst_b = 1'b1;
        wait_init(n);
        chk("init_len", n, 256);
        send(0, 8'h00, '0, '0); get_rsp("init_rd0",   54'h0, lat);
        send(0, 8'h80, '0, '0); get_rsp("init_rd128", 54'h0, lat);
        send(0, 8'hFF, '0, '0); get_rsp("init_rd255", 54'h0, lat);

        // Full-mask write, then read back with latency check
        send(1, 8'h10, 54'h2AAAAA55555555, 54'h3FFFFFFFFFFFFF);
        #1;
        chk("wr_cen",  CEN, 0);
        chk("wr_gwen", GWEN, 0);
        chk("wr_wen",  WEN, 0);
        chk("wr_a",    A, 8'h10);
        chk("wr_d",    D, 54'h2AAAAA55555555);
        send(0, 8'h10, '0, '0);
        get_rsp("raw_data", 54'h2AAAAA55555555, lat);
        chk("rd_latency", lat, 3);

        // Unaligned write: bits 0 and 40 set to 1 by read-modify-write
        send(1, 8'h10, 54'h3FFFFFFFFFFFFF, (54'h1 << 40) | 54'h1);
        #1;
        chk("rmw_rd_cen",  CEN, 0);
        chk("rmw_rd_gwen", GWEN, 1);
        chk("rmw_rd_a",    A, 8'h10);
        chk("rmw_rdy0",    req_rdy, 0);
        @(negedge CLK); #1;
        chk("rmw_rdy1",    req_rdy, 0);
        @(negedge CLK); #1;
        chk("rmw_rdy2",    req_rdy, 1);
        chk("rmw_wr_cen",  CEN, 0);
        chk("rmw_wr_gwen", GWEN, 0);
        chk("rmw_wr_wen",  WEN, 0);
        chk("rmw_wr_d",    D, 54'h2AABAA55555555);
        // Unaligned write clearing bit 2
        send(1, 8'h10, 54'h0, 54'h4);
        send(0, 8'h10, '0, '0);
        get_rsp("rmw_data", 54'h2AABAA55555551, lat);

        // Low-group-only write: one SRAM cycle with split WEN
        send(1, 8'h20, 54'h3FFFFFFFFFFFFF, 54'h0000007FFFFFF);
        #1;
        chk("grp_cen",  CEN, 0);
        chk("grp_gwen", GWEN, 0);
        chk("grp_wen",  WEN, 54'h3FFFFFF8000000);
        chk("grp_a",    A, 8'h20);
        @(negedge CLK); #1;
        chk("grp_single", CEN, 1);
        send(0, 8'h20, '0, '0);
        get_rsp("grp_data", 54'h0000007FFFFFF, lat);

        // Back-pressure: 6 reads with rsp_rdy low, only 4 credits
        bp_addr[0] = 8'h10; bp_exp[0] = 54'h2AABAA55555551;
        bp_addr[1] = 8'h20; bp_exp[1] = 54'h0000007FFFFFF;
        bp_addr[2] = 8'h00; bp_exp[2] = 54'h0;
        bp_addr[3] = 8'h80; bp_exp[3] = 54'h0;
        bp_addr[4] = 8'h10; bp_exp[4] = 54'h2AABAA55555551;
        bp_addr[5] = 8'h20; bp_exp[5] = 54'h0000007FFFFFF;
        bp_addr[6] = 8'h00; bp_exp[6] = 54'h0;
        bp_addr[7] = 8'h00; bp_exp[7] = 54'h0;
        rsp_rdy = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            req_vld = 1'b1; req_wr = 1'b0; req_addr = bp_addr[idx];
            #1;
            if (req_rdy && idx < 7) idx++;
        end
        chk("bp_accepted", idx, 4);
        chk("bp_rdy_low",  req_rdy, 0);
        chk("bp_rsp_vld",  rsp_vld, 1);
        ridx = 0;
        for (int c = 0; c < 60 && ridx < 6; c++) begin
            @(negedge CLK);
            rsp_rdy = 1'b1;
            if (idx < 6) begin req_vld = 1'b1; req_addr = bp_addr[idx]; end
            else req_vld = 1'b0;
            #1;
            if (req_vld && req_rdy && idx < 7) idx++;
            if (rsp_vld) begin
                chk($sformatf("bp_rsp%0d", ridx), rsp_rdata, bp_exp[ridx]);
                ridx++;
            end
        end
        req_vld = 1'b0;
        chk("bp_drained",   ridx, 6);
        chk("bp_all_taken", idx, 6);
        @(negedge CLK);

        // Reset during RMW_RD with a read still in flight
        send(0, 8'h20, '0, '0);
        send(1, 8'h30, 54'h3FFFFFFFFFFFFF, 54'h20);
        #1;
        chk("ab_in_rmw_rd", GWEN, 1);
        chk("ab_rmw_a",     A, 8'h30);
        cpurst_b = 1'b0;
        @(negedge CLK); #1;
        chk("ab_cen",     CEN, 1);
        chk("ab_rsp_vld", rsp_vld, 0);
        chk("ab_req_rdy", req_rdy, 0);
        chk("ab_a",       A, 0);
        @(negedge CLK); #1;
        chk("ab_rsp_vld2", rsp_vld, 0);
        cpurst_b = 1'b1;
        @(negedge CLK); #1;
        chk("ab_init_a",   A, 0);
        chk("ab_init_cen", CEN, 0);
        chk("ab_init_wen", WEN, 0);
        chk("ab_init_d",   D, 0);
        wait_init(n);
        chk("ab_init_len", n, 255);
        send(0, 8'h30, '0, '0); get_rsp("ab_rd30", 54'h0, lat);
        send(0, 8'h10, '0, '0); get_rsp("ab_rd10", 54'h0, lat);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
